// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the load/store stage.
// Data wins by default; a streak counter forces a fetch grant after STREAK_MAX data grants.
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int STREAK_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  // fetch requester
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_valid,
  output logic [XLEN-1:0] if_rdata,
  // load/store requester
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [3:0]      d_be,
  output logic            d_valid,
  output logic [XLEN-1:0] d_rdata,
  // memory port
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  // observation of the arbiter FSM (0=IDLE, 1=BUSY_I, 2=BUSY_D)
  output logic [1:0]      state_dbg
);

  // Handshake: a requester holds req (and its fields) until its valid pulse and
  // must drop or replace req the cycle after. The arbiter samples req only in
  // IDLE. mem_req is held with stable bus fields until a one-cycle mem_ack.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

  state_t        state, state_nx;
  logic [SW-1:0] streak, streak_nx;
  logic          discard, discard_nx;
  logic          grant_i, grant_d;

  always_comb begin
    state_nx   = state;
    streak_nx  = streak;
    discard_nx = discard;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        // a flush pulse in IDLE only blocks the fetch for this one cycle
        if (d_req && if_req && !if_flush && streak == STREAK_LIM) grant_i = 1'b1;
        else if (d_req)                                         grant_d = 1'b1;
        else if (if_req && !if_flush)                           grant_i = 1'b1;

        if (grant_i) begin
          state_nx  = BUSY_I;
          streak_nx = '0;
        end else if (grant_d) begin
          state_nx = BUSY_D;
          if (if_req && streak != STREAK_LIM) streak_nx = streak + 1'b1;
        end
        if (!if_req) streak_nx = '0;
      end
      BUSY_I: begin
        // a flushed fetch still runs to completion on the bus; only its reply is dropped
        if (mem_ack) begin
          state_nx   = IDLE;
          discard_nx = 1'b0;
        end else if (if_flush) begin
          discard_nx = 1'b1;
        end
      end
      BUSY_D: begin
        if (mem_ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      discard   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'h0;
    end else begin
      state   <= state_nx;
      streak  <= streak_nx;
      discard <= discard_nx;
      if (grant_d) begin
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_be    <= d_be;
      end else if (grant_i) begin
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        mem_wdata <= '0;
        mem_be    <= 4'hF;
      end
    end
  end

  // mem_req decodes straight from state so an asynchronous reset drops it at once
  assign mem_req   = (state != IDLE);
  assign if_valid  = mem_ack && (state == BUSY_I) && !discard && !if_flush;
  assign d_valid   = mem_ack && (state == BUSY_D);
  assign if_rdata  = if_valid ? mem_rdata : '0;
  assign d_rdata   = d_valid ? mem_rdata : '0;
  assign state_dbg = state;

endmodule
